// File: rtl/traffic_light_monitor_if.sv
// Lamp observation bundle for traffic_light_monitor.
//   red/amber/green : lamp drives under observation (master -> slave)
//   phase           : tracked phase, 0 IDLE, 1 RED, 2 GREEN, 3 AMBER (slave -> master)
//   err_valid       : one-cycle error pulse
//   err_code        : 1 SEQ, 2 SHORT, 3 LONG, 4 DARK, 5 MULTI, 0 when no error
//   err_sticky      : any error seen since reset
//   cycle_count     : complete, error-free red-green-amber cycles
interface traffic_light_monitor_if;
  logic        red;
  logic        amber;
  logic        green;
  logic [1:0]  phase;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        err_sticky;
  logic [15:0] cycle_count;

  modport master (
    output red, amber, green,
    input  phase, err_valid, err_code, err_sticky, cycle_count
  );

  modport slave (
    input  red, amber, green,
    output phase, err_valid, err_code, err_sticky, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor. Samples the three lamp drives on every
// clock edge, tracks the RED -> GREEN -> AMBER -> RED phase sequence, checks
// each phase length against X_TICS +/- TOL and reports protocol errors.
// Ports:
//   clock   : single clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   mon     : lamp inputs and registered monitor outputs (slave modport)
module traffic_light_monitor #(
  parameter int RED_TICS   = 350,
  parameter int GREEN_TICS = 200,
  parameter int AMBER_TICS = 30,
  parameter int TOL        = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  traffic_light_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_AMBER = 2'd3
  } phase_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SEQ   = 3'd1;
  localparam logic [2:0] ERR_SHORT = 3'd2;
  localparam logic [2:0] ERR_LONG  = 3'd3;
  localparam logic [2:0] ERR_DARK  = 3'd4;
  localparam logic [2:0] ERR_MULTI = 3'd5;

  // Lower bound for a phase ended by a legal transition; may be negative
  // when TOL exceeds the nominal length, hence signed int.
  function automatic int short_limit(input phase_t ph);
    case (ph)
      PH_RED:   return RED_TICS - TOL;
      PH_GREEN: return GREEN_TICS - TOL;
      PH_AMBER: return AMBER_TICS - TOL;
      default:  return 0;
    endcase
  endfunction

  // Counter value at which a phase is first considered too long.
  function automatic int long_limit(input phase_t ph);
    case (ph)
      PH_RED:   return RED_TICS + TOL + 1;
      PH_GREEN: return GREEN_TICS + TOL + 1;
      PH_AMBER: return AMBER_TICS + TOL + 1;
      default:  return 0;
    endcase
  endfunction

  function automatic phase_t next_legal(input phase_t ph);
    case (ph)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_AMBER;
      PH_AMBER: return PH_RED;
      default:  return PH_IDLE;
    endcase
  endfunction

  phase_t      phase_r;
  logic [15:0] cnt_r;
  logic        first_r;
  logic        long_r;
  logic        clean_r;
  logic        err_valid_r;
  logic [2:0]  err_code_r;
  logic        err_sticky_r;
  logic [15:0] cycle_count_r;

  phase_t      phase_s;
  phase_t      colour_s;
  logic [1:0]  lamp_cnt_s;
  logic [15:0] cnt_s;
  logic [15:0] cnt_inc_s;
  logic        first_s;
  logic        long_s;
  logic        clean_s;
  logic [2:0]  code_s;
  logic        count_inc_s;

  // Next-state decision for one lamp sample.
  always_comb begin
    lamp_cnt_s  = {1'b0, mon.red} + {1'b0, mon.amber} + {1'b0, mon.green};
    colour_s    = mon.red ? PH_RED : (mon.green ? PH_GREEN : PH_AMBER);
    cnt_inc_s   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
    phase_s     = phase_r;
    cnt_s       = cnt_r;
    first_s     = first_r;
    long_s      = long_r;
    code_s      = ERR_NONE;
    if (lamp_cnt_s > 2'd1) begin
      code_s  = ERR_MULTI;
      phase_s = PH_IDLE;
      cnt_s   = 16'd0;
      first_s = 1'b0;
      long_s  = 1'b0;
    end else if (lamp_cnt_s == 2'd0) begin
      if (phase_r != PH_IDLE) begin
        code_s = ERR_DARK;
      end else begin
        code_s = ERR_NONE;
      end
      phase_s = PH_IDLE;
      cnt_s   = 16'd0;
      first_s = 1'b0;
      long_s  = 1'b0;
    end else if (phase_r == PH_IDLE) begin
      // Joining mid-phase: length of this first phase is unknown.
      phase_s = colour_s;
      cnt_s   = 16'd1;
      first_s = 1'b1;
      long_s  = 1'b0;
    end else if (colour_s == phase_r) begin
      cnt_s = cnt_inc_s;
      if (!long_r && ($signed({16'd0, cnt_inc_s}) == long_limit(phase_r))) begin
        code_s = ERR_LONG;
        long_s = 1'b1;
      end else begin
        code_s = ERR_NONE;
      end
    end else if (colour_s == next_legal(phase_r)) begin
      // A phase already reported LONG, or only partly observed, is not SHORT.
      if (($signed({16'd0, cnt_r}) < short_limit(phase_r)) && !first_r && !long_r) begin
        code_s = ERR_SHORT;
      end else begin
        code_s = ERR_NONE;
      end
      phase_s = colour_s;
      cnt_s   = 16'd1;
      first_s = 1'b0;
      long_s  = 1'b0;
    end else begin
      code_s  = ERR_SEQ;
      phase_s = colour_s;
      cnt_s   = 16'd1;
      first_s = 1'b1;
      long_s  = 1'b0;
    end

    // An error on the very sample that enters RED leaves the new cycle unclean.
    if (code_s != ERR_NONE) begin
      clean_s = 1'b0;
    end else if ((phase_s == PH_RED) && (phase_r != PH_RED)) begin
      clean_s = 1'b1;
    end else begin
      clean_s = clean_r;
    end

    count_inc_s = (phase_r == PH_AMBER) && (phase_s == PH_RED) && clean_r && (code_s == ERR_NONE);
  end

  // Phase tracking state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_r       <= PH_IDLE;
      cnt_r         <= 16'd0;
      first_r       <= 1'b0;
      long_r        <= 1'b0;
      clean_r       <= 1'b0;
      err_valid_r   <= 1'b0;
      err_code_r    <= ERR_NONE;
      err_sticky_r  <= 1'b0;
      cycle_count_r <= 16'd0;
    end else begin
      phase_r      <= phase_s;
      cnt_r        <= cnt_s;
      first_r      <= first_s;
      long_r       <= long_s;
      clean_r      <= clean_s;
      err_valid_r  <= (code_s != ERR_NONE);
      err_code_r   <= code_s;
      err_sticky_r <= err_sticky_r | (code_s != ERR_NONE);
      if (count_inc_s) begin
        cycle_count_r <= cycle_count_r + 16'd1;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

  assign mon.phase       = phase_r;
  assign mon.err_valid   = err_valid_r;
  assign mon.err_code    = err_code_r;
  assign mon.err_sticky  = err_sticky_r;
  assign mon.cycle_count = cycle_count_r;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_TICS, default 350: required red phase length in clock samples.
REQ-002 Parameter GREEN_TICS, default 200: required green phase length in clock samples.
REQ-003 Parameter AMBER_TICS, default 30: required amber phase length in clock samples.
REQ-004 Parameter TOL, default 0: allowed plus/minus deviation in samples; every X_TICS+TOL SHALL be < 65535.
REQ-005 clock  input  1  single clock; all logic on posedge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 red  input  1  red lamp drive under observation.
REQ-008 amber  input  1  amber lamp drive under observation.
REQ-009 green  input  1  green lamp drive under observation.
REQ-010 phase  output  2  tracked phase: 0 IDLE, 1 RED, 2 GREEN, 3 AMBER.
REQ-011 err_valid  output  1  one-cycle pulse, error detected at this sample.
REQ-012 err_code  output  3  error code: 1 SEQ, 2 SHORT, 3 LONG, 4 DARK, 5 MULTI; 0 when err_valid is low.
REQ-013 err_sticky  output  1  set by any error, cleared only by reset.
REQ-014 cycle_count  output  16  count of complete, error-free red-green-amber cycles.

Function
REQ-015 Lamps SHALL be sampled on every posedge; all outputs SHALL be registered and reflect the sample taken at that same edge.
REQ-016 Sample classification: exactly one lamp high = colour; none high = DARK; two or more high = MULTI.
REQ-017 The block SHALL keep a 16-bit phase counter, saturating at 65535, and a first-phase flag.
REQ-018 IDLE with a DARK sample: stay in IDLE, no error.
REQ-019 IDLE with a colour sample: enter that colour's phase, counter=1, first-phase flag=1.
REQ-020 Any phase with the same colour: counter increments.
REQ-021 LONG: on the sample where the counter becomes X_TICS+TOL+1, pulse LONG once per phase and set a per-phase long-reported flag.
REQ-022 Legal order is RED->GREEN->AMBER->RED.
REQ-023 Legal next colour: if the outgoing counter < X_TICS-TOL, the first-phase flag is 0 and the long-reported flag is 0, pulse SHORT.
REQ-024 Legal next colour: always enter the new phase with counter=1 and clear the first-phase and long-reported flags.
REQ-025 Illegal next colour (e.g. RED->AMBER): pulse SEQ and enter the new colour's phase with counter=1 and first-phase flag=1.
REQ-026 DARK in any non-IDLE phase: pulse DARK and go to IDLE.
REQ-027 MULTI in any state, including IDLE: pulse MULTI and go to IDLE.
REQ-028 A per-cycle clean flag SHALL be set on entering RED and cleared by any error.
REQ-029 On an AMBER->RED transition with the clean flag set and no error that cycle, cycle_count SHALL increment, wrapping 65535->0.
REQ-030 At most one error code SHALL be produced per sample; err_valid/err_code SHALL be high for exactly one cycle per error.
REQ-031 err_sticky SHALL set on the same edge as err_valid.

Reset
REQ-032 While reset_n is low: phase=0, err_valid=0, err_code=0, err_sticky=0, cycle_count=0, counter=0, all flags clear.
REQ-033 Reset asserted mid-phase SHALL abort tracking immediately, without any error pulse.
REQ-034 After reset_n deasserts, the first sample SHALL be treated as arriving in IDLE.

Verification
REQ-035 Reset; red 350, green 200, amber 30, red -> phase sequence 1,2,3,1; no err_valid; cycle_count=1 on the edge entering the second RED.
REQ-036 After one clean cycle, red 349 then green -> err_code=2 for one cycle at the green sample; phase=2; err_sticky=1.
REQ-037 Red held 400 then green -> err_code=3 once, at the 351st red sample; no SHORT or LONG at the transition; phase=2.
REQ-038 Red 350 then amber -> err_code=1; phase=3; no cycle_count increment at the next AMBER->RED.
REQ-039 Mid-green, one DARK sample then red -> err_code=4, phase=0; the next red enters RED with no SHORT at its end; then red and green high together -> err_code=5, phase=0.
REQ-040 Reset_n pulsed low mid-amber with err_sticky=1 and cycle_count=3 -> all outputs 0 immediately; no error on the following samples.
